seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_pkg.sv | 30 +++
 rtl/seq_gen_ctr.sv | 46 ++++
 rtl/seq_gen.sv | 190 +++++++++++++++++++
 tb/tb_seq_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and the
// matching sequence detector.
// Optional feature: SEQ_GEN_GAP_EN adds the GAP state (idle cycles between
// repetitions) to the state type.
package seq_pkg;

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd3
  } state_t;
`endif

  // Default pattern, shared with the sequence detector.
  localparam logic [3:0] SEQ_PAT_DEFAULT = 4'b0110;

  // Width needed to index a pattern of n bits (at least 1).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_gen_ctr.sv
// Bit-index and repetition counters for seq_gen.
// idx is the pattern bit currently on the output; rep counts repetitions
// still owed, including the one in flight, and saturates at 1 so it can
// never wrap.
module seq_gen_ctr
  import seq_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rep_load,
  input  logic [CNT_W-1:0] rep_val,
  input  logic             rep_dec,
  input  logic             idx_load,
  input  logic [IDX_W-1:0] idx_val,
  input  logic             idx_dec,
  output logic [IDX_W-1:0] idx,
  output logic             last_bit,
  output logic             last_rep
);

  logic [CNT_W-1:0] rep;

  // Load on request/restart, otherwise count down without underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      rep <= '0;
    end else begin
      if (rep_load)
        rep <= rep_val;
      else if (rep_dec && (rep > CNT_W'(1)))
        rep <= rep - CNT_W'(1);
      if (idx_load)
        idx <= idx_val;
      else if (idx_dec && (idx != '0))
        idx <= idx - IDX_W'(1);
    end
  end

  assign last_bit = (idx == '0);
  assign last_rep = (rep <= CNT_W'(1));

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends PAT (MSB first) repeat_n times, optionally
// overlapping repetitions by dropping the first OVL_LEN bits of each repeat.
// Optional feature: define SEQ_GEN_GAP_EN to add the gap_len input and idle
// GAP cycles between repetitions.
module seq_gen
  import seq_pkg::*;
#(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PAT     = PAT_W'(SEQ_PAT_DEFAULT),
  parameter int                OVL_LEN = 1,
  parameter int                CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             overlap,
`ifdef SEQ_GEN_GAP_EN
  input  logic [3:0]       gap_len,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             frame_sync,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W     = idx_width(PAT_W);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] OVL_IDX   = IDX_W'(PAT_W - 1 - OVL_LEN);

  state_t           state;
  logic             ovl_q;
  logic [IDX_W-1:0] idx, idx_val, nb_idx, restart_idx;
  logic             last_bit, last_rep;
  logic             rep_load, rep_dec, idx_load, idx_dec;
`ifdef SEQ_GEN_GAP_EN
  logic [3:0]       gap_q, gap_cnt;
`endif

  function automatic logic pat_bit(input logic [IDX_W-1:0] i);
    return PAT[i];
  endfunction

  assign restart_idx = ovl_q ? OVL_IDX : FIRST_IDX;

  seq_gen_ctr #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .rep_load (rep_load),
    .rep_val  (repeat_n),
    .rep_dec  (rep_dec),
    .idx_load (idx_load),
    .idx_val  (idx_val),
    .idx_dec  (idx_dec),
    .idx      (idx),
    .last_bit (last_bit),
    .last_rep (last_rep)
  );

  // Counter control and index of the bit to present next cycle.
  always_comb begin
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    idx_load = 1'b0;
    idx_dec  = 1'b0;
    idx_val  = FIRST_IDX;
    case (state)
      IDLE: if (start) begin
        rep_load = 1'b1;
        idx_load = (repeat_n != '0);
      end
      SEND: if (!last_bit) begin
        idx_dec = 1'b1;
      end else if (!last_rep) begin
        rep_dec = 1'b1;
        idx_val = restart_idx;
`ifdef SEQ_GEN_GAP_EN
        idx_load = (gap_q == 4'd0);
`else
        idx_load = 1'b1;
`endif
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: if (gap_cnt == 4'd1) begin
        idx_load = 1'b1;
        idx_val  = restart_idx;
      end
`endif
      default: ;
    endcase
    nb_idx = idx_load ? idx_val : (idx - IDX_W'(1));
  end

  // FSM with registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ovl_q      <= 1'b0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_q      <= '0;
      gap_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          out        <= 1'b0;
          out_valid  <= 1'b0;
          frame_sync <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            ovl_q <= overlap;
`ifdef SEQ_GEN_GAP_EN
            gap_q <= gap_len;
`endif
            busy  <= 1'b1;
            if (repeat_n != '0) begin
              state      <= SEND;
              out        <= pat_bit(FIRST_IDX);
              out_valid  <= 1'b1;
              frame_sync <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (!last_bit) begin
            out        <= pat_bit(nb_idx);
            out_valid  <= 1'b1;
            frame_sync <= 1'b0;
          end else if (!last_rep) begin
`ifdef SEQ_GEN_GAP_EN
            if (gap_q != 4'd0) begin
              state      <= GAP;
              gap_cnt    <= gap_q;
              out        <= 1'b0;
              out_valid  <= 1'b0;
              frame_sync <= 1'b0;
            end else begin
              out        <= pat_bit(nb_idx);
              out_valid  <= 1'b1;
              frame_sync <= 1'b1;
            end
`else
            out        <= pat_bit(nb_idx);
            out_valid  <= 1'b1;
            frame_sync <= 1'b1;
`endif
          end else begin
            state      <= FIN;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_sync <= 1'b0;
            done       <= 1'b1;
          end
        end
`ifdef SEQ_GEN_GAP_EN
        GAP: begin
          if (gap_cnt == 4'd1) begin
            state      <= SEND;
            out        <= pat_bit(nb_idx);
            out_valid  <= 1'b1;
            frame_sync <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
`endif
        FIN: begin
          state      <= IDLE;
          out        <= 1'b0;
          out_valid  <= 1'b0;
          frame_sync <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: the driver pushes the expected bit stream
// of each request, a negedge monitor pops and compares every valid bit.
module tb_seq_gen;
  import seq_pkg::*;

  localparam int PAT_W   = 4;
  localparam int OVL_LEN = 1;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset, start, overlap;
  logic [CNT_W-1:0] repeat_n;
  logic             out, out_valid, frame_sync, busy, done;
`ifdef SEQ_GEN_GAP_EN
  logic [3:0]       gap_len;
`endif

  typedef struct packed { logic b; logic fs; } exp_t;
  exp_t       q[$];
  exp_t       e;
  logic [3:0] pat_v = 4'b0110;
  logic [3:0] win;
  int         win_n, obs_bits, obs_hits;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  seq_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .repeat_n   (repeat_n),
    .overlap    (overlap),
`ifdef SEQ_GEN_GAP_EN
    .gap_len    (gap_len),
`endif
    .out        (out),
    .out_valid  (out_valid),
    .frame_sync (frame_sync),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference stream: repetition r starts at the MSB, or OVL_LEN bits later
  // on repeats in overlap mode; returns the number of valid bits pushed.
  task automatic push_model(input int n, input bit ovl, output int nbits);
    int st;
    nbits = 0;
    for (int r = 0; r < n; r++) begin
      st = (r > 0 && ovl) ? PAT_W - 1 - OVL_LEN : PAT_W - 1;
      for (int b = st; b >= 0; b--) begin
        q.push_back('{b: pat_v[b], fs: (b == st)});
        nbits++;
      end
    end
  endtask

  // Monitor: compare every valid bit against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        obs_bits++;
        win = {win[2:0], out};
        win_n++;
        if (win_n >= 4 && win == 4'b0110) obs_hits++;
        if (q.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bit", out, e.b);
          chk("frame_sync", frame_sync, e.fs);
        end
      end else begin
        chk("out_zero_when_invalid", out, 0);
      end
      if (done) chk("queue_empty_at_done", q.size(), 0);
    end
  end

  task automatic run_req(input int n, input bit ovl, input int gl, input bit noise,
                         input int exp_hits);
    int mbits, exp_bits, gaps, c, budget;
    bit seen;
    push_model(n, ovl, mbits);
    if (n == 0) exp_bits = 0;
    else exp_bits = ovl ? PAT_W + (n - 1) * (PAT_W - OVL_LEN) : n * PAT_W;
`ifdef SEQ_GEN_GAP_EN
    gaps = (n > 1) ? gl * (n - 1) : 0;
`else
    gaps = 0;
`endif
    budget = exp_bits + gaps + 10;
    @(negedge clk);
    obs_bits = 0; obs_hits = 0; win_n = 0;
    start = 1'b1; repeat_n = CNT_W'(n); overlap = ovl;
`ifdef SEQ_GEN_GAP_EN
    gap_len = 4'(gl);
`endif
    @(negedge clk);
    start = 1'b0;
    c = 1;
    seen = 1'b0;
    if (n > 0) chk("first_bit_latency", out_valid, 1);
    while (!seen && c < budget) begin
      if (done) begin
        seen = 1'b1;
        chk("done_latency", c, exp_bits + gaps + 1);
        chk("busy_at_done", busy, 1);
        chk("valid_at_done", out_valid, 0);
      end else begin
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          repeat_n = CNT_W'($urandom);
          overlap = 1'($urandom_range(0, 1));
`ifdef SEQ_GEN_GAP_EN
          gap_len = 4'($urandom);
`endif
        end
        @(negedge clk);
        c++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_fin", busy, 0);
    chk("valid_bit_count", obs_bits, exp_bits);
    if (exp_hits >= 0) chk("detector_hits", obs_hits, exp_hits);
  endtask

  initial begin
    int vcount, c, nb;
    reset = 1'b1; start = 1'b0; repeat_n = '0; overlap = 1'b0;
    win = '0; win_n = 0; obs_bits = 0; obs_hits = 0;
`ifdef SEQ_GEN_GAP_EN
    gap_len = '0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_out", out, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;

    run_req(1, 1'b0, 0, 1'b0, 1);
    run_req(3, 1'b0, 0, 1'b0, 3);
    run_req(3, 1'b1, 0, 1'b0, 3);
    run_req(0, 1'b0, 0, 1'b0, 0);
    run_req(2, 1'b1, 0, 1'b1, -1);
`ifdef SEQ_GEN_GAP_EN
    run_req(2, 1'b0, 2, 1'b0, 2);
    run_req(3, 1'b1, 0, 1'b0, 3);
`endif

    // Reset in the middle of a 5-repetition request.
    push_model(5, 1'b0, nb);
    @(negedge clk);
    start = 1'b1; repeat_n = 8'd5; overlap = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vcount = 0; c = 0;
    while (vcount < 3 && c < 50) begin
      if (out_valid) vcount++;
      if (vcount < 3) begin
        @(negedge clk);
        c++;
      end
    end
    chk("reached_third_bit", vcount, 3);
    #2 reset = 1'b1;
    #1;
    chk("midreset_out", out, 0);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_fs", frame_sync, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_req(1, 1'b0, 0, 1'b0, 1);

    // Largest repeat count, both modes.
    run_req(255, 1'b0, 0, 1'b0, -1);
    run_req(255, 1'b1, 0, 1'b0, -1);

    for (int i = 0; i < 25; i++)
      run_req($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
